// File: rtl/design_calc_fifo.sv
// Calc FIFO: start enqueues a OP b, result/check read the head, check dequeues.
// Occupancy is exported and any enable-while-not-ready sets a sticky error.
module design_calc_fifo #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 4,
  parameter int OP    = 0
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic [WIDTH-1:0]           start_a,
  input  logic [WIDTH-1:0]           start_b,
  input  logic                       EN_start,
  output logic                       RDY_start,
  input  logic [WIDTH-1:0]           result_c,
  output logic [WIDTH-1:0]           result,
  output logic                       RDY_result,
  input  logic [WIDTH-1:0]           check_d,
  input  logic                       EN_check,
  output logic [WIDTH-1:0]           check,
  output logic                       RDY_check,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       proto_err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    cnt;
  logic             err;

  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             bad;
  logic [WIDTH-1:0] op_res;
  logic [WIDTH-1:0] head;

  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);

  assign push = EN_start && !full;
  assign pop  = EN_check && !empty;
  assign bad  = (EN_start && full) || (EN_check && empty);

  // Result width equals operand width, so all ops wrap mod 2^WIDTH.
  always_comb begin
    op_res = '0;
    case (OP)
      1:       op_res = start_a - start_b;
      2:       op_res = start_a * start_b;
      default: op_res = start_a + start_b;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= op_res;
    end
  end

  // Power-of-two depth: pointers wrap naturally.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt <= '0;
    end else begin
      unique case (1'b1)
        push && !pop: cnt <= cnt + 1'b1;
        pop && !push: cnt <= cnt - 1'b1;
        default:      cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      err <= 1'b0;
    end else if (bad) begin
      err <= 1'b1;
    end
  end

  assign head = mem[rd_ptr];

  assign RDY_start  = !full;
  assign RDY_result = !empty;
  assign RDY_check  = !empty;
  assign result     = empty ? '0 : head + result_c;
  assign check      = empty ? '0 : head ^ check_d;
  assign count      = cnt;
  assign proto_err  = err;

endmodule

// File: tb/tb_design_calc_fifo.sv
// Directed bench for design_calc_fifo: three instances cover OP=0/1/2.
// Inputs change 1 time unit after a rising edge; outputs sampled before the next edge.
module tb_design_calc_fifo;

  localparam int W = 7;
  localparam int D = 4;
  localparam int CW = $clog2(D + 1);

  logic          CLK = 1'b0;
  logic          RST_N = 1'b1;
  logic [W-1:0]  start_a = '0;
  logic [W-1:0]  start_b = '0;
  logic          EN_start = 1'b0;
  logic [W-1:0]  result_c = '0;
  logic [W-1:0]  check_d = '0;
  logic          EN_check = 1'b0;

  logic          rdy_s0, rdy_r0, rdy_c0, perr0;
  logic [W-1:0]  res0, chk0;
  logic [CW-1:0] cnt0;
  logic          rdy_s1, rdy_r1, rdy_c1, perr1;
  logic [W-1:0]  res1, chk1;
  logic [CW-1:0] cnt1;
  logic          rdy_s2, rdy_r2, rdy_c2, perr2;
  logic [W-1:0]  res2, chk2;
  logic [CW-1:0] cnt2;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  design_calc_fifo #(.WIDTH(W), .DEPTH(D), .OP(0)) u0 (
    .CLK(CLK), .RST_N(RST_N),
    .start_a(start_a), .start_b(start_b),
    .EN_start(EN_start), .RDY_start(rdy_s0),
    .result_c(result_c), .result(res0), .RDY_result(rdy_r0),
    .check_d(check_d), .EN_check(EN_check),
    .check(chk0), .RDY_check(rdy_c0),
    .count(cnt0), .proto_err(perr0)
  );

  design_calc_fifo #(.WIDTH(W), .DEPTH(D), .OP(1)) u1 (
    .CLK(CLK), .RST_N(RST_N),
    .start_a(start_a), .start_b(start_b),
    .EN_start(EN_start), .RDY_start(rdy_s1),
    .result_c(result_c), .result(res1), .RDY_result(rdy_r1),
    .check_d(check_d), .EN_check(EN_check),
    .check(chk1), .RDY_check(rdy_c1),
    .count(cnt1), .proto_err(perr1)
  );

  design_calc_fifo #(.WIDTH(W), .DEPTH(D), .OP(2)) u2 (
    .CLK(CLK), .RST_N(RST_N),
    .start_a(start_a), .start_b(start_b),
    .EN_start(EN_start), .RDY_start(rdy_s2),
    .result_c(result_c), .result(res2), .RDY_result(rdy_r2),
    .check_d(check_d), .EN_check(EN_check),
    .check(chk2), .RDY_check(rdy_c2),
    .count(cnt2), .proto_err(perr2)
  );

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    EN_start = 1'b0;
    EN_check = 1'b0;
    start_a  = '0;
    start_b  = '0;
    result_c = '0;
    check_d  = '0;
  endtask

  task automatic pulse_reset();
    idle();
    RST_N = 1'b0;
    #3;
    RST_N = 1'b1;
    cyc();
  endtask

  task automatic push(input int a, input int b);
    start_a  = W'(a);
    start_b  = W'(b);
    EN_start = 1'b1;
    cyc();
    EN_start = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    cyc();
    push(7, 8);
    push(1, 1);
    result_c = 5;
    #2;
    RST_N = 1'b0;
    #1;
    checks++;
    if (cnt0 !== 3'd0) begin
      errors++;
      $display("FAIL reset_count got=%0d exp=0", cnt0);
    end
    checks++;
    if (rdy_s0 !== 1'b1 || rdy_r0 !== 1'b0 || rdy_c0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_rdy got=%b%b%b exp=100", rdy_s0, rdy_r0, rdy_c0);
    end
    checks++;
    if (res0 !== 7'd0 || chk0 !== 7'd0) begin
      errors++;
      $display("FAIL reset_data got=%0d/%0d exp=0/0", res0, chk0);
    end
    checks++;
    if (perr0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_perr got=%b exp=0", perr0);
    end
    #1;
    RST_N = 1'b1;
    idle();
    cyc();
  endtask

  task automatic test_basic();
    pulse_reset();
    push(5, 3);
    checks++;
    if (rdy_r0 !== 1'b1 || cnt0 !== 3'd1) begin
      errors++;
      $display("FAIL basic_enq got rdy=%b cnt=%0d exp rdy=1 cnt=1", rdy_r0, cnt0);
    end
    result_c = 2;
    check_d  = 1;
    #1;
    checks++;
    if (res0 !== 7'd10) begin
      errors++;
      $display("FAIL basic_result got=%0d exp=10", res0);
    end
    checks++;
    if (chk0 !== 7'd9) begin
      errors++;
      $display("FAIL basic_check got=%0d exp=9", chk0);
    end
    EN_check = 1'b1;
    cyc();
    EN_check = 1'b0;
    checks++;
    if (cnt0 !== 3'd0 || rdy_c0 !== 1'b0 || perr0 !== 1'b0) begin
      errors++;
      $display("FAIL basic_deq got cnt=%0d rdy=%b perr=%b exp 0/0/0", cnt0, rdy_c0, perr0);
    end
    EN_check = 1'b1;
    cyc();
    EN_check = 1'b0;
    checks++;
    if (perr0 !== 1'b1 || cnt0 !== 3'd0) begin
      errors++;
      $display("FAIL empty_check got perr=%b cnt=%0d exp 1/0", perr0, cnt0);
    end
  endtask

  task automatic test_full();
    int exp_q[3];
    exp_q = '{4, 6, 8};
    pulse_reset();
    for (int i = 1; i <= 4; i++) push(i, i);
    checks++;
    if (rdy_s0 !== 1'b0 || cnt0 !== 3'd4) begin
      errors++;
      $display("FAIL full_state got rdy=%b cnt=%0d exp 0/4", rdy_s0, cnt0);
    end
    start_a  = 9;
    start_b  = 9;
    EN_start = 1'b1;
    EN_check = 1'b1;
    check_d  = 0;
    #1;
    checks++;
    if (chk0 !== 7'd2) begin
      errors++;
      $display("FAIL full_head got=%0d exp=2", chk0);
    end
    cyc();
    EN_start = 1'b0;
    EN_check = 1'b0;
    checks++;
    if (perr0 !== 1'b1 || cnt0 !== 3'd3) begin
      errors++;
      $display("FAIL full_ignore got perr=%b cnt=%0d exp 1/3", perr0, cnt0);
    end
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (chk0 !== W'(exp_q[k])) begin
        errors++;
        $display("FAIL full_order[%0d] got=%0d exp=%0d", k, chk0, exp_q[k]);
      end
      EN_check = 1'b1;
      cyc();
      EN_check = 1'b0;
    end
    checks++;
    if (cnt0 !== 3'd0 || rdy_s0 !== 1'b1) begin
      errors++;
      $display("FAIL full_drain got cnt=%0d rdy=%b exp 0/1", cnt0, rdy_s0);
    end
  endtask

  task automatic test_back_to_back();
    pulse_reset();
    push(1, 0);
    push(2, 0);
    for (int k = 0; k < 10; k++) begin
      start_a  = W'(k + 3);
      start_b  = 0;
      check_d  = 0;
      EN_start = 1'b1;
      EN_check = 1'b1;
      #1;
      checks++;
      if (chk0 !== W'(k + 1)) begin
        errors++;
        $display("FAIL b2b_head[%0d] got=%0d exp=%0d", k, chk0, k + 1);
      end
      cyc();
      checks++;
      if (cnt0 !== 3'd2) begin
        errors++;
        $display("FAIL b2b_count[%0d] got=%0d exp=2", k, cnt0);
      end
    end
    idle();
    #1;
    checks++;
    if (res0 !== 7'd11 || perr0 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end got head=%0d perr=%b exp 11/0", res0, perr0);
    end
    cyc();
  endtask

  task automatic test_wrap_ops();
    pulse_reset();
    push(127, 1);
    result_c = 0;
    #1;
    checks++;
    if (res0 !== 7'd0 || rdy_r0 !== 1'b1) begin
      errors++;
      $display("FAIL add_wrap got=%0d rdy=%b exp 0/1", res0, rdy_r0);
    end
    result_c = 127;
    #1;
    checks++;
    if (res0 !== 7'd127) begin
      errors++;
      $display("FAIL add_result got=%0d exp=127", res0);
    end
    pulse_reset();
    push(0, 1);
    #1;
    checks++;
    if (res1 !== 7'd127) begin
      errors++;
      $display("FAIL sub_wrap got=%0d exp=127", res1);
    end
    pulse_reset();
    push(12, 11);
    #1;
    checks++;
    if (res2 !== 7'd4) begin
      errors++;
      $display("FAIL mul_wrap got=%0d exp=4", res2);
    end
  endtask

  task automatic test_reset_flush();
    pulse_reset();
    push(1, 2);
    push(3, 4);
    push(5, 6);
    checks++;
    if (cnt0 !== 3'd3) begin
      errors++;
      $display("FAIL flush_fill got=%0d exp=3", cnt0);
    end
    pulse_reset();
    checks++;
    if (cnt0 !== 3'd0 || rdy_c0 !== 1'b0) begin
      errors++;
      $display("FAIL flush_state got cnt=%0d rdy=%b exp 0/0", cnt0, rdy_c0);
    end
    push(6, 6);
    #1;
    checks++;
    if (res0 !== 7'd12 || cnt0 !== 3'd1) begin
      errors++;
      $display("FAIL flush_head got=%0d cnt=%0d exp 12/1", res0, cnt0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_back_to_back();
    test_wrap_ops();
    test_reset_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
